// File: rtl/brightness_pkg.sv
// Shared types and constants for the brightness fade controller.
package brightness_pkg;

  localparam int INTENSITY_W = 8;
  localparam logic [INTENSITY_W-1:0] INTENSITY_MAX = 8'd255;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } fade_state_e;

  // A zero step would stall the ramp forever, so it is promoted to 1.
  function automatic logic [INTENSITY_W-1:0] step_or_one(input logic [INTENSITY_W-1:0] s);
    return (s == '0) ? INTENSITY_W'(1) : s;
  endfunction

endpackage

// File: rtl/intensity_stepper.sv
// Combinational saturating step: moves cur toward target by at most step, never overshooting.
module intensity_stepper
  import brightness_pkg::*;
(
  input  logic [INTENSITY_W-1:0] cur,
  input  logic [INTENSITY_W-1:0] target,
  input  logic [INTENSITY_W-1:0] step,
  output logic [INTENSITY_W-1:0] next,
  output logic                   at_target
);

  logic [INTENSITY_W:0] diff_up;
  logic [INTENSITY_W:0] diff_dn;
  logic [INTENSITY_W:0] step_w;

  assign diff_up = {1'b0, target} - {1'b0, cur};
  assign diff_dn = {1'b0, cur} - {1'b0, target};
  assign step_w  = {1'b0, step};

  // cur+step / cur-step are only taken when the distance exceeds step, so they cannot wrap.
  always_comb begin
    next = cur;
    if (target >= cur) begin
      next = (diff_up <= step_w) ? target : cur + step;
    end else begin
      next = (diff_dn <= step_w) ? target : cur - step;
    end
  end

  assign at_target = (next == target);

endmodule

// File: rtl/brightness_fade_ctrl.sv
// Fade sequencer for the brightness filter intensity; updates only on frame ends.
// Optional FADE_DONE_IRQ_EN adds a sticky irq flag with irq_clr.
module brightness_fade_ctrl
  import brightness_pkg::*;
#(
  parameter logic [INTENSITY_W-1:0] INIT_INTENSITY = INTENSITY_MAX,
  parameter int                     FRAME_DIV_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   st_valid,
  input  logic                   st_ready,
  input  logic                   st_eop,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [INTENSITY_W-1:0] cmd_target,
  input  logic [INTENSITY_W-1:0] cmd_step,
  input  logic [FRAME_DIV_W-1:0] cmd_div,
  input  logic                   cmd_abort,
  output logic [INTENSITY_W-1:0] intensity,
  output logic                   busy,
  output logic                   done,
  output logic                   fsm_state
`ifdef FADE_DONE_IRQ_EN
  ,
  output logic                   irq,
  input  logic                   irq_clr
`endif
);

  // Command handshake: a command transfers on a cycle with cmd_valid & cmd_ready;
  // cmd_ready is high exactly while IDLE, and cmd_valid is ignored otherwise.

  localparam logic [FRAME_DIV_W-1:0] DIV_ONE = FRAME_DIV_W'(1);

  fade_state_e            state, state_nx;
  logic [INTENSITY_W-1:0] intensity_q, intensity_nx;
  logic [INTENSITY_W-1:0] target_q, target_nx;
  logic [INTENSITY_W-1:0] step_q, step_nx;
  logic [FRAME_DIV_W-1:0] div_q, div_nx;
  logic [FRAME_DIV_W-1:0] frame_cnt, frame_cnt_nx;
  logic                   done_q, done_nx;
  logic [INTENSITY_W-1:0] step_next;
  logic                   step_at_target;
  logic                   frame_end;

  assign frame_end = st_valid & st_ready & st_eop;

  intensity_stepper u_stepper (
    .cur       (intensity_q),
    .target    (target_q),
    .step      (step_q),
    .next      (step_next),
    .at_target (step_at_target)
  );

  always_comb begin
    state_nx     = state;
    intensity_nx = intensity_q;
    target_nx    = target_q;
    step_nx      = step_q;
    div_nx       = div_q;
    frame_cnt_nx = frame_cnt;
    done_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          target_nx    = cmd_target;
          step_nx      = step_or_one(cmd_step);
          div_nx       = (cmd_div == '0) ? DIV_ONE : cmd_div;
          frame_cnt_nx = '0;
          if (cmd_target == intensity_q) done_nx  = 1'b1;
          else                           state_nx = RAMP;
        end
      end
      RAMP: begin
        // Abort outranks a coincident frame end: intensity freezes, no done.
        if (cmd_abort) begin
          state_nx     = IDLE;
          frame_cnt_nx = '0;
        end else if (frame_end) begin
          if (frame_cnt == div_q - DIV_ONE) begin
            frame_cnt_nx = '0;
            intensity_nx = step_next;
            if (step_at_target) begin
              state_nx = IDLE;
              done_nx  = 1'b1;
            end
          end else begin
            frame_cnt_nx = frame_cnt + DIV_ONE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      intensity_q <= INIT_INTENSITY;
      target_q    <= INIT_INTENSITY;
      step_q      <= INTENSITY_W'(1);
      div_q       <= DIV_ONE;
      frame_cnt   <= '0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_nx;
      intensity_q <= intensity_nx;
      target_q    <= target_nx;
      step_q      <= step_nx;
      div_q       <= div_nx;
      frame_cnt   <= frame_cnt_nx;
      done_q      <= done_nx;
    end
  end

`ifdef FADE_DONE_IRQ_EN
  // Set tracks done_nx so irq rises together with the done pulse; set beats clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       irq <= 1'b0;
    else if (done_nx) irq <= 1'b1;
    else if (irq_clr) irq <= 1'b0;
  end
`endif

  assign intensity = intensity_q;
  assign cmd_ready = (state == IDLE);
  assign busy      = (state == RAMP);
  assign done      = done_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_brightness_fade_ctrl.sv
// Self-checking bench for brightness_fade_ctrl: scoreboard of expected intensity per frame end.
module tb_brightness_fade_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       st_valid, st_ready, st_eop;
  logic       cmd_valid, cmd_ready, cmd_abort;
  logic [7:0] cmd_target, cmd_step, cmd_div;
  logic [7:0] intensity;
  logic       busy, done, fsm_state;
`ifdef FADE_DONE_IRQ_EN
  logic       irq;
  logic       irq_clr = 1'b0;
`endif

  int         check_cnt = 0;
  int         pass_cnt  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  int         model;

  always #5 clk = ~clk;

  brightness_fade_ctrl #(.INIT_INTENSITY(8'd255), .FRAME_DIV_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_eop     (st_eop),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_step   (cmd_step),
    .cmd_div    (cmd_div),
    .cmd_abort  (cmd_abort),
    .intensity  (intensity),
    .busy       (busy),
    .done       (done),
    .fsm_state  (fsm_state)
`ifdef FADE_DONE_IRQ_EN
    ,
    .irq        (irq),
    .irq_clr    (irq_clr)
`endif
  );

  // ---------------- driver tasks (inputs change on negedge) ----------------
  task automatic send_cmd(input logic [7:0] t, input logic [7:0] s, input logic [7:0] d,
                          input logic with_fe);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_target = t; cmd_step = s; cmd_div = d;
    st_valid = with_fe; st_ready = with_fe; st_eop = with_fe;
    @(negedge clk);
    cmd_valid = 1'b0; st_valid = 1'b0; st_ready = 1'b0; st_eop = 1'b0;
  endtask

  task automatic drive_frame(input logic v, input logic r, input logic e);
    @(negedge clk);
    st_valid = v; st_ready = r; st_eop = e;
    @(negedge clk);
    st_valid = 1'b0; st_ready = 1'b0; st_eop = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    st_valid = 0; st_ready = 0; st_eop = 0; cmd_valid = 0; cmd_abort = 0;
    cmd_target = 0; cmd_step = 0; cmd_div = 0;
    repeat (3) @(negedge clk);
    check_cnt++; if (intensity !== 8'd255) $display("FAIL reset_intensity: got %0d want 255", intensity); else pass_cnt++;
    check_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done: got %b%b want 00", busy, done); else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    check_cnt++; if (fsm_state !== 1'b0) $display("FAIL reset_state: got %b want 0", fsm_state); else pass_cnt++;
  endtask

  task automatic test_fade_down();
    send_cmd(8'd0, 8'd64, 8'd1, 1'b0);
    check_cnt++; if (busy !== 1'b1 || cmd_ready !== 1'b0) $display("FAIL down_accept: busy=%b ready=%b want 1 0", busy, cmd_ready); else pass_cnt++;
    exp_q.push_back(8'd191); exp_q.push_back(8'd127); exp_q.push_back(8'd63); exp_q.push_back(8'd0);
    for (int i = 0; i < 4; i++) begin
      drive_frame(1'b1, 1'b1, 1'b1);
      exp_v = exp_q.pop_front();
      check_cnt++; if (intensity !== exp_v) $display("FAIL down_step%0d: got %0d want %0d", i, intensity, exp_v); else pass_cnt++;
      check_cnt++; if (done !== (i == 3)) $display("FAIL down_done%0d: got %b want %b", i, done, (i == 3)); else pass_cnt++;
    end
    check_cnt++; if (busy !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL down_end: busy=%b ready=%b want 0 1", busy, cmd_ready); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (done !== 1'b0) $display("FAIL down_done_pulse: got %b want 0", done); else pass_cnt++;
  endtask

  task automatic test_fade_up_div();
    send_cmd(8'd200, 8'd100, 8'd3, 1'b0);
    exp_q.push_back(8'd0);   exp_q.push_back(8'd0);   exp_q.push_back(8'd100);
    exp_q.push_back(8'd100); exp_q.push_back(8'd100); exp_q.push_back(8'd200);
    for (int i = 0; i < 6; i++) begin
      drive_frame(1'b1, 1'b1, 1'b1);
      exp_v = exp_q.pop_front();
      check_cnt++; if (intensity !== exp_v) $display("FAIL up_div_frame%0d: got %0d want %0d", i, intensity, exp_v); else pass_cnt++;
      check_cnt++; if (done !== (i == 5)) $display("FAIL up_div_done%0d: got %b want %b", i, done, (i == 5)); else pass_cnt++;
    end
  endtask

  task automatic test_same_target();
    send_cmd(8'd128, 8'd72, 8'd1, 1'b0);
    drive_frame(1'b1, 1'b1, 1'b1);
    check_cnt++; if (intensity !== 8'd128 || done !== 1'b1) $display("FAIL to128: got %0d done=%b want 128 1", intensity, done); else pass_cnt++;
    @(negedge clk);
    send_cmd(8'd128, 8'd5, 8'd1, 1'b0);
    check_cnt++; if (done !== 1'b1) $display("FAIL same_done: got %b want 1", done); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL same_idle: busy=%b ready=%b want 0 1", busy, cmd_ready); else pass_cnt++;
    check_cnt++; if (intensity !== 8'd128) $display("FAIL same_intensity: got %0d want 128", intensity); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (done !== 1'b0) $display("FAIL same_done_pulse: got %b want 0", done); else pass_cnt++;
  endtask

  task automatic test_abort();
    send_cmd(8'd0, 8'd1, 8'd1, 1'b0);
    drive_frame(1'b1, 1'b1, 1'b1);
    check_cnt++; if (intensity !== 8'd127) $display("FAIL abort_pre: got %0d want 127", intensity); else pass_cnt++;
    @(negedge clk);
    st_valid = 1'b1; st_ready = 1'b1; st_eop = 1'b1; cmd_abort = 1'b1;
    @(negedge clk);
    st_valid = 1'b0; st_ready = 1'b0; st_eop = 1'b0; cmd_abort = 1'b0;
    check_cnt++; if (intensity !== 8'd127) $display("FAIL abort_freeze: got %0d want 127", intensity); else pass_cnt++;
    check_cnt++; if (fsm_state !== 1'b0 || busy !== 1'b0) $display("FAIL abort_idle: state=%b busy=%b want 0 0", fsm_state, busy); else pass_cnt++;
    check_cnt++; if (done !== 1'b0) $display("FAIL abort_done: got %b want 0", done); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (done !== 1'b0) $display("FAIL abort_done_late: got %b want 0", done); else pass_cnt++;
  endtask

  task automatic test_zero_step_div();
    send_cmd(8'd130, 8'd0, 8'd0, 1'b0);
    exp_q.push_back(8'd128); exp_q.push_back(8'd129); exp_q.push_back(8'd130);
    for (int i = 0; i < 3; i++) begin
      drive_frame(1'b1, 1'b1, 1'b1);
      exp_v = exp_q.pop_front();
      check_cnt++; if (intensity !== exp_v) $display("FAIL zero_step%0d: got %0d want %0d", i, intensity, exp_v); else pass_cnt++;
    end
    check_cnt++; if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done); else pass_cnt++;
  endtask

  task automatic test_no_handshake_reset();
    logic [5:0] v_tab, r_tab, e_tab;
    v_tab = 6'b111001; r_tab = 6'b110010; e_tab = 6'b110111;   // bit i = frame i
    send_cmd(8'd0, 8'd10, 8'd2, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'd130);
    exp_q.push_back(8'd130); exp_q.push_back(8'd120);
    for (int i = 0; i < 6; i++) begin
      drive_frame(v_tab[i], r_tab[i], e_tab[i]);
      exp_v = exp_q.pop_front();
      check_cnt++; if (intensity !== exp_v) $display("FAIL nohs_frame%0d: got %0d want %0d", i, intensity, exp_v); else pass_cnt++;
    end
    #2 reset = 1'b0;
    #1;
    check_cnt++; if (intensity !== 8'd255) $display("FAIL async_reset_intensity: got %0d want 255", intensity); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL async_reset_idle: busy=%b ready=%b want 0 1", busy, cmd_ready); else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_back_to_back();
    send_cmd(8'd0, 8'd255, 8'd1, 1'b1);
    check_cnt++; if (intensity !== 8'd255 || busy !== 1'b1) $display("FAIL accept_fe: got %0d busy=%b want 255 1", intensity, busy); else pass_cnt++;
    drive_frame(1'b1, 1'b1, 1'b1);
    check_cnt++; if (intensity !== 8'd0 || done !== 1'b1) $display("FAIL b2b_down: got %0d done=%b want 0 1", intensity, done); else pass_cnt++;
    send_cmd(8'd255, 8'd200, 8'd1, 1'b0);
    exp_q.push_back(8'd200); exp_q.push_back(8'd255);
    for (int i = 0; i < 2; i++) begin
      drive_frame(1'b1, 1'b1, 1'b1);
      exp_v = exp_q.pop_front();
      check_cnt++; if (intensity !== exp_v) $display("FAIL b2b_up%0d: got %0d want %0d", i, intensity, exp_v); else pass_cnt++;
    end
    check_cnt++; if (done !== 1'b1) $display("FAIL b2b_done: got %b want 1", done); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [7:0] t, s, d;
    model = 255;
    for (int n = 0; n < 5; n++) begin
      t = 8'($urandom_range(0, 255));
      s = 8'($urandom_range(16, 80));
      d = 8'($urandom_range(1, 2));
      if (int'(t) == model) t = t ^ 8'h80;
      while (model != int'(t)) begin
        for (int k = 1; k < int'(d); k++) exp_q.push_back(8'(model));
        if (int'(t) > model) model = (model + int'(s) >= int'(t)) ? int'(t) : model + int'(s);
        else                 model = (model - int'(s) <= int'(t)) ? int'(t) : model - int'(s);
        exp_q.push_back(8'(model));
      end
      send_cmd(t, s, d, 1'b0);
      for (int f = 0; f < 300 && exp_q.size() > 0; f++) begin
        drive_frame(1'b1, 1'b1, 1'b1);
        exp_v = exp_q.pop_front();
        check_cnt++; if (intensity !== exp_v) $display("FAIL rand%0d_frame%0d: got %0d want %0d", n, f, intensity, exp_v); else pass_cnt++;
        check_cnt++; if (done !== (exp_q.size() == 0)) $display("FAIL rand%0d_done%0d: got %b want %b", n, f, done, (exp_q.size() == 0)); else pass_cnt++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_fade_down();
    test_fade_up_div();
    test_same_target();
    test_abort();
    test_zero_step_div();
    test_no_handshake_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
